// File: rtl/spi_slave.sv
// spi_slave: SPI peripheral that oversamples sclk/mosi/select in the clk domain.
// It shifts Width-bit frames MSB-first in all four cpol/cpha modes. Transmit data
// comes from a single-entry buffer, and a ready strobe marks each received byte.
module spi_slave #(
  parameter int               Width = 8,
  parameter logic [Width-1:0] Idle  = 8'hFF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             mosi,
  input  logic             select,
  output logic             miso,
  input  logic [Width-1:0] din,
  input  logic             load,
  output logic             txfull,
  output logic [Width-1:0] dout,
  output logic             ready,
  output logic             busy
);

  localparam int CountWidth = (Width > 1) ? $clog2(Width) : 1;
  localparam logic [CountWidth-1:0] LastBit = CountWidth'(Width - 1);

  typedef enum logic {
    IDLE,
    ACTIVE
  } state_t;

  state_t state;
  state_t next_state;

  logic sclk_meta;
  logic sclk_sync;
  logic sclk_last;
  logic mosi_meta;
  logic mosi_sync;
  logic select_meta;
  logic select_sync;
  logic select_last;

  logic mode_cpol;
  logic mode_cpha;

  logic [Width-1:0]      tx_shift;
  logic [Width-1:0]      txbuf;
  logic [Width-2:0]      rx_shift;
  logic [Width-1:0]      rx_next;
  logic [CountWidth-1:0] bitcnt;
  logic                  boundary;

  logic sclk_edge;
  logic leading_edge;
  logic trailing_edge;
  logic sample_edge;
  logic shift_edge;
  logic select_fall;

  logic start_frame;
  logic end_frame;
  logic do_sample;
  logic do_shift;
  logic do_reload;
  logic consume;

  // The select flops reset low, so a select that is already low after reset never
  // looks like a falling edge. The pin must be seen high before a frame is joined.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sclk_meta   <= 1'b0;
      sclk_sync   <= 1'b0;
      sclk_last   <= 1'b0;
      mosi_meta   <= 1'b0;
      mosi_sync   <= 1'b0;
      select_meta <= 1'b0;
      select_sync <= 1'b0;
      select_last <= 1'b0;
    end else begin
      sclk_meta   <= sclk;
      sclk_sync   <= sclk_meta;
      sclk_last   <= sclk_sync;
      mosi_meta   <= mosi;
      mosi_sync   <= mosi_meta;
      select_meta <= select;
      select_sync <= select_meta;
      select_last <= select_sync;
    end
  end

  assign sclk_edge     = sclk_sync ^ sclk_last;
  assign leading_edge  = sclk_edge && (sclk_last == mode_cpol);
  assign trailing_edge = sclk_edge && (sclk_sync == mode_cpol);
  assign sample_edge   = mode_cpha ? trailing_edge : leading_edge;
  assign shift_edge    = mode_cpha ? leading_edge : trailing_edge;
  assign select_fall   = select_last & ~select_sync;

  // State register for the frame tracker.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Decide the next state, and which datapath action this cycle's edges trigger.
  always_comb begin
    next_state  = state;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    do_sample   = 1'b0;
    do_shift    = 1'b0;
    do_reload   = 1'b0;
    case (state)
      IDLE: begin
        if (select_fall) begin
          next_state  = ACTIVE;
          start_frame = 1'b1;
        end
      end
      ACTIVE: begin
        if (select_sync) begin
          next_state = IDLE;
          end_frame  = 1'b1;
        end else if (sample_edge) begin
          do_sample = 1'b1;
        end else if (shift_edge) begin
          if (mode_cpha && (bitcnt == '0)) begin
            do_reload = boundary;
          end else if (!mode_cpha && boundary) begin
            do_reload = 1'b1;
          end else begin
            do_shift = 1'b1;
          end
        end
      end
      default: next_state = IDLE;
    endcase
  end

  assign consume = start_frame | do_reload;
  assign rx_next = {rx_shift, mosi_sync};
  assign miso    = (state == ACTIVE) ? tx_shift[Width-1] : 1'b0;
  assign busy    = (state == ACTIVE);

  // The mode is frozen for the whole frame at the moment select is joined.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_cpol <= 1'b0;
      mode_cpha <= 1'b0;
    end else if (start_frame) begin
      mode_cpol <= cpol;
      mode_cpha <= cpha;
    end
  end

  // The transmit shift register takes the buffered byte (or Idle) at each byte start.
  always_ff @(posedge clk) begin
    if (!reset) begin
      tx_shift <= '0;
    end else if (consume) begin
      tx_shift <= txfull ? txbuf : Idle;
    end else if (do_shift) begin
      tx_shift <= {tx_shift[Width-2:0], 1'b0};
    end
  end

  // Single-entry transmit buffer. A load in the same cycle as a consume keeps it full.
  always_ff @(posedge clk) begin
    if (!reset) begin
      txbuf  <= '0;
      txfull <= 1'b0;
    end else if (load) begin
      txbuf  <= din;
      txfull <= 1'b1;
    end else if (consume) begin
      txfull <= 1'b0;
    end
  end

  // Receive path: count sampled bits, publish a completed byte, and flag the boundary.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_shift <= '0;
      bitcnt   <= '0;
      boundary <= 1'b0;
      dout     <= '0;
      ready    <= 1'b0;
    end else begin
      ready <= 1'b0;
      if (start_frame || end_frame) begin
        rx_shift <= '0;
        bitcnt   <= '0;
        boundary <= 1'b0;
      end else if (do_sample) begin
        rx_shift <= rx_next[Width-2:0];
        if (bitcnt == LastBit) begin
          dout     <= rx_next;
          ready    <= 1'b1;
          bitcnt   <= '0;
          boundary <= 1'b1;
        end else begin
          bitcnt <= bitcnt + 1'b1;
        end
      end else if (do_reload) begin
        boundary <= 1'b0;
      end
    end
  end

endmodule
